pixel_coord_gen: RTL and testbench

Parametrised successor to the camera column counter. Synchronises OV7670-style VSYNC/HREF/PCLK/D into the system clock domain. Assembles multi-byte pixels and produces a column index and a row index for each pixel. Adds frame/line framing pulses, overflow detection and frame-boundary arming for the downstream frame-buffer writer and the visual-control pipeline.

---
 rtl/pixel_coord_gen.sv | 157 +++++++++++++++
 tb/tb_pixel_coord_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_gen.sv
// Camera capture front end: synchronises OV7670-style VSYNC/HREF/PCLK/D into CLK,
// assembles multi-byte pixels and tags each with its column and row.
module pixel_coord_gen #(
    parameter int COL_W           = 10,
    parameter int ROW_W           = 9,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int MAX_COLS        = 640,
    parameter int MAX_ROWS        = 480,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         VSYNC,
    input  logic                         HREF,
    input  logic                         PCLK,
    input  logic [7:0]                   D,
    output logic [8*BYTES_PER_PIXEL-1:0] PIXEL_DATA,
    output logic                         PIXEL_VALID,
    output logic [COL_W-1:0]             PIXEL_COLUMN,
    output logic [ROW_W-1:0]             PIXEL_ROW,
    output logic                         FRAME_START,
    output logic                         FRAME_END,
    output logic                         LINE_END,
    output logic [COL_W-1:0]             LINE_LEN,
    output logic                         COL_OVF,
    output logic                         ROW_OVF
);

    localparam int              PW        = 8 * BYTES_PER_PIXEL;
    localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [COL_W:0]  MAX_C     = (COL_W + 1)'(MAX_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAX_ROWS - 1);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t                          state;
    logic [SYNC_STAGES-1:0]          vs_sync, hr_sync, pc_sync;
    logic [SYNC_STAGES-1:0][7:0]     d_sync;
    logic                            vs, hr, pc, vs_d, hr_d, pc_d;
    logic [7:0]                      d;
    logic                            pclk_rise, href_on, href_fall, vs_rise, vs_fall;
    logic [PW-1:0]                   asm_q, asm_next;
    logic [1:0]                      byte_cnt;
    // One extra bit so the column can sit at MAX_COLS when MAX_COLS == 2^COL_W.
    logic [COL_W:0]                  col;
    logic [ROW_W-1:0]                row;

    assign vs = vs_sync[SYNC_STAGES-1];
    assign hr = hr_sync[SYNC_STAGES-1];
    assign pc = pc_sync[SYNC_STAGES-1];
    assign d  = d_sync[SYNC_STAGES-1];

    assign pclk_rise = pc & ~pc_d;
    assign href_on   = hr & hr_d;
    assign href_fall = ~hr & hr_d;
    assign vs_rise   = vs & ~vs_d;
    assign vs_fall   = ~vs & vs_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_sync <= '0;
            hr_sync <= '0;
            pc_sync <= '0;
            d_sync  <= '0;
            vs_d    <= 1'b0;
            hr_d    <= 1'b0;
            pc_d    <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[SYNC_STAGES-2:0], VSYNC};
            hr_sync <= {hr_sync[SYNC_STAGES-2:0], HREF};
            pc_sync <= {pc_sync[SYNC_STAGES-2:0], PCLK};
            d_sync  <= {d_sync[SYNC_STAGES-2:0], D};
            vs_d    <= vs;
            hr_d    <= hr;
            pc_d    <= pc;
        end
    end

    always_comb begin
        asm_next      = asm_q << 8;
        asm_next[7:0] = d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            asm_q        <= '0;
            byte_cnt     <= '0;
            col          <= '0;
            row          <= '0;
            PIXEL_DATA   <= '0;
            PIXEL_VALID  <= 1'b0;
            PIXEL_COLUMN <= '0;
            PIXEL_ROW    <= '0;
            FRAME_START  <= 1'b0;
            FRAME_END    <= 1'b0;
            LINE_END     <= 1'b0;
            LINE_LEN     <= '0;
            COL_OVF      <= 1'b0;
            ROW_OVF      <= 1'b0;
        end else begin
            PIXEL_VALID <= 1'b0;
            FRAME_START <= 1'b0;
            FRAME_END   <= 1'b0;
            LINE_END    <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_fall && START) begin
                        state       <= ARMED;
                        FRAME_START <= 1'b1;
                        col         <= '0;
                        row         <= '0;
                        byte_cnt    <= '0;
                        COL_OVF     <= 1'b0;
                        ROW_OVF     <= 1'b0;
                    end
                end
                ARMED: begin
                    if (pclk_rise && href_on && !vs) begin
                        asm_q <= asm_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            if (col < MAX_C) begin
                                PIXEL_DATA   <= asm_next;
                                PIXEL_VALID  <= 1'b1;
                                PIXEL_COLUMN <= col[COL_W-1:0];
                                PIXEL_ROW    <= row;
                                col          <= col + (COL_W + 1)'(1);
                            end else begin
                                COL_OVF <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    // href_fall excludes href_on, so this never competes with a byte capture.
                    if (href_fall) begin
                        LINE_END <= 1'b1;
                        LINE_LEN <= col[COL_W] ? '1 : col[COL_W-1:0];
                        col      <= '0;
                        byte_cnt <= '0;
                        if (col != '0) begin
                            if (row < ROW_LAST) row <= row + ROW_W'(1);
                            else                ROW_OVF <= 1'b1;
                        end
                    end
                    if (vs_rise) begin
                        state     <= IDLE;
                        FRAME_END <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen: a 2-byte/4-column/3-row instance and a 1-byte
// instance, checked every cycle against a transaction-level expectation queue.
module tb_pixel_coord_gen;

    localparam int LAT = 3;  // two synchroniser flops + registered output

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_in [2];
    logic       hr_in [2];
    logic       pc_in [2];
    logic       st_in [2];
    logic [7:0] d_in  [2];
    int         cyc = 0;
    int         total = 0;
    int         passes = 0;

    logic [15:0] pd0;   logic [7:0] pd1;
    logic        pv0, pv1, fs0, fs1, fe0, fe1, le0, le1, co0, co1, ro0, ro1;
    logic [9:0]  pcol0, pcol1, ll0, ll1;
    logic [8:0]  prow0, prow1;

    pixel_coord_gen #(.BYTES_PER_PIXEL(2), .MAX_COLS(4), .MAX_ROWS(3)) dut0 (
        .CLK(clk), .RST(rst), .START(st_in[0]), .VSYNC(vs_in[0]), .HREF(hr_in[0]),
        .PCLK(pc_in[0]), .D(d_in[0]), .PIXEL_DATA(pd0), .PIXEL_VALID(pv0),
        .PIXEL_COLUMN(pcol0), .PIXEL_ROW(prow0), .FRAME_START(fs0), .FRAME_END(fe0),
        .LINE_END(le0), .LINE_LEN(ll0), .COL_OVF(co0), .ROW_OVF(ro0));

    pixel_coord_gen #(.BYTES_PER_PIXEL(1)) dut1 (
        .CLK(clk), .RST(rst), .START(st_in[1]), .VSYNC(vs_in[1]), .HREF(hr_in[1]),
        .PCLK(pc_in[1]), .D(d_in[1]), .PIXEL_DATA(pd1), .PIXEL_VALID(pv1),
        .PIXEL_COLUMN(pcol1), .PIXEL_ROW(prow1), .FRAME_START(fs1), .FRAME_END(fe1),
        .LINE_END(le1), .LINE_LEN(ll1), .COL_OVF(co1), .ROW_OVF(ro1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events: kind 0 pixel, 1 frame start, 2 frame end, 3 line end.
    typedef struct {
        int          idx;
        int          kind;
        int          due;
        logic [31:0] data;
        int          col;
        int          row;
    } ev_t;
    ev_t evq[$];

    int m_armed [2] = '{0, 0};
    int m_col   [2] = '{0, 0};
    int m_row   [2] = '{0, 0};
    int m_bpp   [2] = '{2, 1};
    int m_maxc  [2] = '{4, 640};
    int m_maxr  [2] = '{3, 480};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int idx, input int kind, input logic [31:0] data,
                        input int col, input int row);
        ev_t e;
        e.idx = idx; e.kind = kind; e.due = cyc + LAT;
        e.data = data; e.col = col; e.row = row;
        evq.push_back(e);
    endtask

    function automatic logic get_pulse(input int idx, input int kind);
        case (kind)
            0:       return idx == 0 ? pv0 : pv1;
            1:       return idx == 0 ? fs0 : fs1;
            2:       return idx == 0 ? fe0 : fe1;
            default: return idx == 0 ? le0 : le1;
        endcase
    endfunction

    int          c_found;
    logic        c_act;
    logic [31:0] c_data;
    int          c_col, c_row;

    always @(negedge clk) begin
        if (!rst) begin
            for (int idx = 0; idx < 2; idx++) begin
                for (int kind = 0; kind < 4; kind++) begin
                    c_act   = get_pulse(idx, kind);
                    c_found = -1;
                    foreach (evq[i])
                        if (evq[i].idx == idx && evq[i].kind == kind && evq[i].due == cyc)
                            c_found = i;
                    if (c_act || c_found >= 0) begin
                        total++;
                        if (c_found < 0) begin
                            $display("FAIL event[%0d] kind %0d: got unexpected pulse at cycle %0d",
                                     idx, kind, cyc);
                        end else if (!c_act) begin
                            $display("FAIL event[%0d] kind %0d: got no pulse, expected one at cycle %0d",
                                     idx, kind, cyc);
                        end else if (kind == 0) begin
                            c_data = idx == 0 ? 32'(pd0) : 32'(pd1);
                            c_col  = idx == 0 ? int'(pcol0) : int'(pcol1);
                            c_row  = idx == 0 ? int'(prow0) : int'(prow1);
                            if (c_data == evq[c_found].data && c_col == evq[c_found].col &&
                                c_row == evq[c_found].row)
                                passes++;
                            else
                                $display("FAIL pixel[%0d]: got %0h c%0d r%0d expected %0h c%0d r%0d",
                                         idx, c_data, c_col, c_row, evq[c_found].data,
                                         evq[c_found].col, evq[c_found].row);
                        end else begin
                            passes++;
                        end
                        if (c_found >= 0) evq.delete(c_found);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        evq.delete();
        m_armed[0] = 0;
        m_armed[1] = 0;
        rst = 1'b1;
        step(1);
        check("rst_zero0", 32'(|{pd0, pv0, pcol0, prow0, fs0, fe0, le0, ll0, co0, ro0}), 0);
        check("rst_zero1", 32'(|{pd1, pv1, pcol1, prow1, fs1, fe1, le1, ll1, co1, ro1}), 0);
        check("rst_col0", 32'(pcol0), 0);
        rst = 1'b0;
    endtask

    task automatic frame_begin(input int idx);
        vs_in[idx] = 1'b1;
        step(4);
        vs_in[idx] = 1'b0;
        if (st_in[idx]) begin
            m_armed[idx] = 1; m_col[idx] = 0; m_row[idx] = 0;
            push(idx, 1, 0, 0, 0);
        end
        step(4);
    endtask

    task automatic frame_end(input int idx);
        vs_in[idx] = 1'b1;
        if (m_armed[idx] != 0) push(idx, 2, 0, 0, 0);
        m_armed[idx] = 0;
        step(4);
    endtask

    // Sends n bytes base, base+0x11, ...; rst_after >= 0 resets before that byte.
    task automatic send_line(input int idx, input int n, input logic [7:0] base,
                             input int rst_after);
        logic [7:0]  b;
        logic [31:0] acc;
        hr_in[idx] = 1'b1;
        step(2);
        acc = '0;
        for (int i = 0; i < n; i++) begin
            if (i == rst_after) do_reset();
            b = base + 8'(17 * i);
            d_in[idx]  = b;
            pc_in[idx] = 1'b1;
            acc = {acc[23:0], b};
            if ((i + 1) % m_bpp[idx] == 0) begin
                if (m_armed[idx] != 0 && m_col[idx] < m_maxc[idx]) begin
                    push(idx, 0, acc & (32'hFFFF_FFFF >> (32 - 8 * m_bpp[idx])),
                         m_col[idx], m_row[idx]);
                    m_col[idx]++;
                end
                acc = '0;
            end
            step(2);
            pc_in[idx] = 1'b0;
            step(2);
        end
        hr_in[idx] = 1'b0;
        if (m_armed[idx] != 0) begin
            push(idx, 3, 0, 0, 0);
            if (m_col[idx] > 0 && m_row[idx] < m_maxr[idx] - 1) m_row[idx]++;
        end
        m_col[idx] = 0;
        step(4);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vs_in[i] = 1'b0; hr_in[i] = 1'b0; pc_in[i] = 1'b0; d_in[i] = '0; st_in[i] = 1'b1;
        end
        step(3);
        check("reset_state0", 32'(|{pd0, pv0, pcol0, prow0, fs0, fe0, le0, ll0, co0, ro0}), 0);
        check("reset_state1", 32'(|{pd1, pv1, pcol1, prow1, fs1, fe1, le1, ll1, co1, ro1}), 0);
        rst = 1'b0;
        step(2);

        // Two lines of four pixels.
        frame_begin(0);
        send_line(0, 8, 8'hA1, -1);
        check("t1_linelen_l0", 32'(ll0), 4);
        send_line(0, 8, 8'h29, -1);
        frame_end(0);
        check("t1_hold_data", 32'(pd0), 32'h8FA0);
        check("t1_hold_col", 32'(pcol0), 3);
        check("t1_hold_row", 32'(prow0), 1);
        check("t1_linelen", 32'(ll0), 4);
        check("t1_colovf", 32'(co0), 0);

        // Column overflow, then odd-byte line.
        frame_begin(0);
        send_line(0, 12, 8'h01, -1);
        check("t2_linelen", 32'(ll0), 4);
        check("t2_colovf", 32'(co0), 1);
        frame_end(0);
        check("t2_colovf_sticky", 32'(co0), 1);
        frame_begin(0);
        check("t2_colovf_clr", 32'(co0), 0);
        send_line(0, 3, 8'h10, -1);
        check("t3_linelen", 32'(ll0), 1);
        check("t3_data", 32'(pd0), 32'h1021);
        send_line(0, 4, 8'h40, -1);
        check("t3_pair_data", 32'(pd0), 32'h6273);
        check("t3_pair_col", 32'(pcol0), 1);
        check("t3_pair_row", 32'(prow0), 1);
        frame_end(0);

        // START low at frame start, raised mid-frame.
        st_in[0] = 1'b0;
        frame_begin(0);
        step(2);
        st_in[0] = 1'b1;
        send_line(0, 4, 8'h33, -1);
        frame_end(0);
        frame_begin(0);
        send_line(0, 4, 8'h44, -1);
        check("t4_data", 32'(pd0), 32'h6677);
        check("t4_row", 32'(prow0), 0);
        frame_end(0);

        // Row overflow at MAX_ROWS = 3.
        frame_begin(0);
        send_line(0, 2, 8'h80, -1);
        send_line(0, 2, 8'h80, -1);
        send_line(0, 2, 8'h80, -1);
        check("rowovf_edge", 32'(ro0), 1);
        send_line(0, 2, 8'h80, -1);
        check("rowovf_row", 32'(prow0), 2);
        check("rowovf_sticky", 32'(ro0), 1);
        frame_end(0);

        // Reset after two pixels of row 1.
        frame_begin(0);
        send_line(0, 8, 8'h01, -1);
        send_line(0, 8, 8'h11, 4);
        send_line(0, 4, 8'h21, -1);
        frame_end(0);
        frame_begin(0);
        send_line(0, 2, 8'hC0, -1);
        check("t5_data", 32'(pd0), 32'hC0D1);
        check("t5_col", 32'(pcol0), 0);
        check("t5_row", 32'(prow0), 0);
        frame_end(0);

        // One byte per pixel, PCLK at CLK/4.
        frame_begin(1);
        send_line(1, 8, 8'h05, -1);
        check("t6_linelen8", 32'(ll1), 8);
        send_line(1, 3, 8'hF0, -1);
        check("t6_linelen3", 32'(ll1), 3);
        check("t6_data", 32'(pd1), 32'h12);
        check("t6_col", 32'(pcol1), 2);
        check("t6_row", 32'(prow1), 1);
        frame_end(1);

        step(10);
        check("queue_empty", 32'(evq.size()), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
